// File: rtl/axi_nport_bridge.sv
// NUM_CH-client to single AXI3 master bridge with independent round-robin read and write paths.
// Optional read-after-write line hazard check: define AXI_RAW_HAZARD_CHK_EN.
module axi_nport_bridge #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 4,
  parameter int LINE_W = 6
) (
  input  logic                 clk,
  input  logic                 rset,
  input  logic [NUM_CH*32-1:0] ch_addr,
  input  logic [NUM_CH-1:0]    ch_addr_valid,
  input  logic [NUM_CH-1:0]    ch_we,
  input  logic [NUM_CH*3-1:0]  ch_size,
  input  logic [NUM_CH*8-1:0]  ch_lens,
  input  logic [NUM_CH-1:0]    ch_rready,
  input  logic [NUM_CH*32-1:0] ch_wr_data,
  input  logic [NUM_CH-1:0]    ch_wr_valid,
  input  logic [NUM_CH*4-1:0]  ch_byte_enable,
  input  logic [NUM_CH-1:0]    ch_wr_last,
  input  logic [NUM_CH-1:0]    ch_resp_ready,
  output logic [NUM_CH-1:0]    ch_valid_clear,
  output logic [NUM_CH-1:0]    ch_rd_dready,
  output logic [31:0]          ch_rd_data,
  output logic [NUM_CH-1:0]    ch_rlast,
  output logic [NUM_CH-1:0]    ch_wr_next,
  output logic [NUM_CH-1:0]    ch_wr_finish,
  output logic [31:0]          axi_araddr,
  output logic [ID_W-1:0]      axi_arid,
  output logic [7:0]           axi_arlen,
  output logic [2:0]           axi_arsize,
  output logic [1:0]           axi_arburst,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  output logic [3:0]           axi_arcache,
  output logic [1:0]           axi_arlock,
  output logic [2:0]           axi_arprot,
  input  logic [31:0]          axi_rdata,
  input  logic [ID_W-1:0]      axi_rid,
  input  logic                 axi_rlast,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rvalid,
  output logic                 axi_rready,
  output logic [31:0]          axi_awaddr,
  output logic [ID_W-1:0]      axi_awid,
  output logic [7:0]           axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [3:0]           axi_awcache,
  output logic [1:0]           axi_awlock,
  output logic [2:0]           axi_awprot,
  output logic [31:0]          axi_wdata,
  output logic [3:0]           axi_wstrb,
  output logic [ID_W-1:0]      axi_wid,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [ID_W-1:0]      axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t        r_r_state;
  wr_state_t        r_w_state;
  logic [CH_W-1:0]  r_rd_ptr, r_rd_ch, r_wr_ptr, r_wr_ch;
  logic [31:0]      r_araddr, r_awaddr;
  logic [ID_W-1:0]  r_arid, r_awid;
  logic [7:0]       r_arlen, r_awlen;
  logic [2:0]       r_arsize, r_awsize;
  logic             r_arvalid, r_awvalid;

  logic [31:0]      w_addr [NUM_CH];
  logic [31:0]      w_wdata [NUM_CH];
  logic [7:0]       w_len [NUM_CH];
  logic [2:0]       w_size [NUM_CH];
  logic [3:0]       w_strb [NUM_CH];
  logic [NUM_CH-1:0] w_rd_haz, w_rd_chsel, w_wr_chsel;
  logic             w_rd_found, w_wr_found;
  logic [CH_W-1:0]  w_rd_sel, w_wr_sel, w_rd_idx, w_wr_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign w_addr[g]  = ch_addr[32*g +: 32];
    assign w_wdata[g] = ch_wr_data[32*g +: 32];
    assign w_len[g]   = ch_lens[8*g +: 8];
    assign w_size[g]  = ch_size[3*g +: 3];
    assign w_strb[g]  = ch_byte_enable[4*g +: 4];
  end

`ifdef AXI_RAW_HAZARD_CHK_EN
  function automatic logic f_same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINE_W] == b[31:LINE_W];
  endfunction

  // A read may not overtake an in-flight write to the same cache line.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_rd_haz[c] = (r_w_state != W_IDLE) && f_same_line(w_addr[c], r_awaddr);
    end
  end
`else
  assign w_rd_haz = '0;
`endif

  // Round-robin search: descending loop so the lowest offset from the pointer wins.
  always_comb begin
    w_rd_found = 1'b0;
    w_rd_sel   = '0;
    w_rd_idx   = '0;
    w_wr_found = 1'b0;
    w_wr_sel   = '0;
    w_wr_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_rd_idx = CH_W'((int'(r_rd_ptr) + k) % NUM_CH);
      w_wr_idx = CH_W'((int'(r_wr_ptr) + k) % NUM_CH);
      if (ch_addr_valid[w_rd_idx] && !ch_we[w_rd_idx] && !w_rd_haz[w_rd_idx]) begin
        w_rd_found = 1'b1;
        w_rd_sel   = w_rd_idx;
      end
      if (ch_addr_valid[w_wr_idx] && ch_we[w_wr_idx]) begin
        w_wr_found = 1'b1;
        w_wr_sel   = w_wr_idx;
      end
    end
  end

  // Read path FSM.
  always_ff @(posedge clk) begin
    if (rset) begin
      r_r_state <= R_IDLE;
      r_rd_ptr  <= '0;
      r_rd_ch   <= '0;
      r_araddr  <= 32'h0000_0000;
      r_arid    <= '0;
      r_arlen   <= 8'h00;
      r_arsize  <= 3'b000;
      r_arvalid <= 1'b0;
    end else begin
      case (r_r_state)
        R_IDLE: if (w_rd_found) begin
          r_rd_ch   <= w_rd_sel;
          r_araddr  <= w_addr[w_rd_sel];
          r_arid    <= ID_W'(w_rd_sel);
          r_arlen   <= w_len[w_rd_sel];
          r_arsize  <= w_size[w_rd_sel];
          r_arvalid <= 1'b1;
          r_r_state <= R_ADDR;
        end
        R_ADDR: if (axi_arready) begin
          r_arvalid <= 1'b0;
          r_r_state <= R_DATA;
        end
        R_DATA: if (axi_rvalid && axi_rready && axi_rlast) begin
          r_r_state <= R_IDLE;
          r_rd_ptr  <= (r_rd_ch == CH_W'(NUM_CH - 1)) ? '0 : r_rd_ch + CH_W'(1);
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  // Write path FSM.
  always_ff @(posedge clk) begin
    if (rset) begin
      r_w_state <= W_IDLE;
      r_wr_ptr  <= '0;
      r_wr_ch   <= '0;
      r_awaddr  <= 32'h0000_0000;
      r_awid    <= '0;
      r_awlen   <= 8'h00;
      r_awsize  <= 3'b000;
      r_awvalid <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: if (w_wr_found) begin
          r_wr_ch   <= w_wr_sel;
          r_awaddr  <= w_addr[w_wr_sel];
          r_awid    <= ID_W'(w_wr_sel);
          r_awlen   <= w_len[w_wr_sel];
          r_awsize  <= w_size[w_wr_sel];
          r_awvalid <= 1'b1;
          r_w_state <= W_ADDR;
        end
        W_ADDR: if (axi_awready) begin
          r_awvalid <= 1'b0;
          r_w_state <= W_DATA;
        end
        W_DATA: if (axi_wvalid && axi_wready && axi_wlast) r_w_state <= W_RESP;
        W_RESP: if (axi_bvalid && axi_bready) begin
          r_w_state <= W_IDLE;
          r_wr_ptr  <= (r_wr_ch == CH_W'(NUM_CH - 1)) ? '0 : r_wr_ch + CH_W'(1);
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // One-hot decode of the granted channel of each path.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_rd_chsel[c] = (r_rd_ch == CH_W'(c));
      w_wr_chsel[c] = (r_wr_ch == CH_W'(c));
    end
  end

  assign axi_araddr  = r_araddr;
  assign axi_arid    = r_arid;
  assign axi_arlen   = r_arlen;
  assign axi_arsize  = r_arsize;
  assign axi_arvalid = r_arvalid;
  assign axi_arburst = 2'b01;
  assign axi_arcache = 4'b0000;
  assign axi_arlock  = 2'b00;
  assign axi_arprot  = 3'b000;
  assign axi_awaddr  = r_awaddr;
  assign axi_awid    = r_awid;
  assign axi_awlen   = r_awlen;
  assign axi_awsize  = r_awsize;
  assign axi_awvalid = r_awvalid;
  assign axi_awburst = 2'b01;
  assign axi_awcache = 4'b0000;
  assign axi_awlock  = 2'b00;
  assign axi_awprot  = 3'b000;

  assign axi_rready   = (r_r_state == R_DATA) && ch_rready[r_rd_ch];
  assign ch_rd_dready = w_rd_chsel & {NUM_CH{axi_rvalid && axi_rready}};
  assign ch_rlast     = w_rd_chsel & {NUM_CH{(r_r_state == R_DATA) && axi_rlast}};
  assign ch_rd_data   = axi_rdata;

  // W channel is a straight pass-through of the granted client during the data phase.
  assign axi_wdata    = w_wdata[r_wr_ch];
  assign axi_wstrb    = w_strb[r_wr_ch];
  assign axi_wid      = r_awid;
  assign axi_wvalid   = (r_w_state == W_DATA) && ch_wr_valid[r_wr_ch];
  assign axi_wlast    = (r_w_state == W_DATA) && ch_wr_last[r_wr_ch];
  assign ch_wr_next   = w_wr_chsel & {NUM_CH{axi_wvalid && axi_wready}};
  assign axi_bready   = (r_w_state == W_RESP) && ch_resp_ready[r_wr_ch];
  assign ch_wr_finish = w_wr_chsel & {NUM_CH{axi_bvalid && axi_bready}};

  assign ch_valid_clear = (w_rd_chsel & {NUM_CH{r_arvalid && axi_arready}}) |
                          (w_wr_chsel & {NUM_CH{r_awvalid && axi_awready}});

  wire w_unused = ^{axi_rid, axi_rresp, axi_bid, axi_bresp, LINE_W[0]};
endmodule

// File: tb/tb_axi_nport_bridge.sv
// Directed bench for axi_nport_bridge: client and AXI slave models, vector table plus corner sequences.
module tb_axi_nport_bridge;
  localparam int NC = 2;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic rset = 1'b1;
  always #5 clk = ~clk;

  logic [NC*32-1:0] ch_addr, ch_wr_data;
  logic [NC-1:0]    ch_addr_valid, ch_we, ch_rready, ch_wr_valid, ch_wr_last, ch_resp_ready;
  logic [NC*3-1:0]  ch_size;
  logic [NC*8-1:0]  ch_lens;
  logic [NC*4-1:0]  ch_byte_enable;
  logic [NC-1:0]    ch_valid_clear, ch_rd_dready, ch_rlast, ch_wr_next, ch_wr_finish;
  logic [31:0]      ch_rd_data;
  logic [31:0]      axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic [ID_W-1:0]  axi_arid, axi_awid, axi_rid, axi_wid, axi_bid;
  logic [7:0]       axi_arlen, axi_awlen;
  logic [2:0]       axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]       axi_arburst, axi_awburst, axi_arlock, axi_awlock, axi_rresp, axi_bresp;
  logic [3:0]       axi_arcache, axi_awcache, axi_wstrb;
  logic axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

  axi_nport_bridge #(.NUM_CH(NC), .ID_W(ID_W), .LINE_W(6)) dut (
    .clk(clk), .rset(rset), .ch_addr(ch_addr), .ch_addr_valid(ch_addr_valid), .ch_we(ch_we),
    .ch_size(ch_size), .ch_lens(ch_lens), .ch_rready(ch_rready), .ch_wr_data(ch_wr_data),
    .ch_wr_valid(ch_wr_valid), .ch_byte_enable(ch_byte_enable), .ch_wr_last(ch_wr_last),
    .ch_resp_ready(ch_resp_ready), .ch_valid_clear(ch_valid_clear), .ch_rd_dready(ch_rd_dready),
    .ch_rd_data(ch_rd_data), .ch_rlast(ch_rlast), .ch_wr_next(ch_wr_next), .ch_wr_finish(ch_wr_finish),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arcache(axi_arcache), .axi_arlock(axi_arlock), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awcache(axi_awcache), .axi_awlock(axi_awlock), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wid(axi_wid), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int checks = 0;
  int failures = 0;

  // client model
  logic [31:0] m_addr [NC];
  logic [7:0]  m_len [NC];
  logic        m_reqv [NC];
  logic        m_we [NC];
  logic        wc_act [NC];
  int          wc_idx [NC];
  int          rx_idx [NC];
  // slave model
  logic s_rd_pend, s_w_act, s_b_pend;
  int s_rd_idx, s_w_idx, s_b_wait;
  logic [7:0] s_rd_len, s_w_len;
  logic [ID_W-1:0] s_rd_id, s_w_id, s_b_id;
  // knobs
  int b_delay = 0;
  logic rv_toggle = 1'b0;
  int stall_at = -1;
  int stall_left = 0;
  logic [1:0] rresp_k = 2'b00;
  // statistics
  int clr_cnt [NC], rd_cnt [NC], rl_cnt [NC], wn_cnt [NC], fin_cnt [NC];
  int ar_log [$];
  int aw_log [$];
  int cyc = 0;
  int ar_cyc, aw_cyc, b_cyc, arv_cyc;
  logic [31:0] cap_araddr, cap_awaddr;
  logic [7:0] cap_arlen, cap_awlen;
  logic [2:0] cap_arsize;
  logic [ID_W-1:0] cap_arid, cap_awid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NC; c++) begin
      clr_cnt[c] = 0; rd_cnt[c] = 0; rl_cnt[c] = 0; wn_cnt[c] = 0; fin_cnt[c] = 0; rx_idx[c] = 0;
    end
    ar_log.delete(); aw_log.delete();
    ar_cyc = -1; aw_cyc = -1; b_cyc = -1; arv_cyc = -1;
  endtask

  task automatic clear_model();
    for (int c = 0; c < NC; c++) begin
      m_reqv[c] = 1'b0; m_we[c] = 1'b0; m_addr[c] = 32'h0; m_len[c] = 8'h0;
      wc_act[c] = 1'b0; wc_idx[c] = 0;
    end
    s_rd_pend = 1'b0; s_w_act = 1'b0; s_b_pend = 1'b0;
    s_rd_idx = 0; s_w_idx = 0; s_b_wait = 0;
    s_rd_len = 8'h0; s_w_len = 8'h0; s_rd_id = '0; s_w_id = '0; s_b_id = '0;
  endtask

  task automatic req(input int c, input logic we, input logic [31:0] a, input logic [7:0] len);
    m_reqv[c] = 1'b1; m_we[c] = we; m_addr[c] = a; m_len[c] = len;
  endtask

  function automatic logic idle();
    logic busy;
    busy = s_rd_pend | s_w_act | s_b_pend;
    for (int c = 0; c < NC; c++) busy = busy | m_reqv[c] | wc_act[c];
    return !busy;
  endfunction

  // One clock: drive inputs 1 ns after the edge, sample 1 ns later and advance the models.
  task automatic step();
    logic stall_now;
    @(posedge clk); #1; cyc++;
    stall_now = (stall_left > 0) && s_rd_pend && (s_rd_idx == stall_at);
    if (stall_now) stall_left--;
    for (int c = 0; c < NC; c++) begin
      ch_addr[32*c +: 32] = m_addr[c];
      ch_addr_valid[c] = m_reqv[c];
      ch_we[c] = m_we[c];
      ch_lens[8*c +: 8] = m_len[c];
      ch_size[3*c +: 3] = 3'd2;
      ch_rready[c] = !stall_now;
      ch_wr_valid[c] = wc_act[c];
      ch_wr_data[32*c +: 32] = 32'hA000_0000 | (32'(c) << 16) | 32'(wc_idx[c]);
      ch_wr_last[c] = wc_act[c] && (wc_idx[c] == int'(m_len[c]));
      ch_byte_enable[4*c +: 4] = (c == 0) ? 4'hF : 4'h3;
      ch_resp_ready[c] = 1'b1;
    end
    axi_arready = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    axi_rvalid = s_rd_pend && (!rv_toggle || cyc[0]);
    axi_rdata = 32'hD000_0000 | (32'(s_rd_id) << 16) | 32'(s_rd_idx);
    axi_rlast = s_rd_pend && (s_rd_idx == int'(s_rd_len));
    axi_rid = s_rd_id; axi_rresp = rresp_k;
    if (s_b_pend && s_b_wait > 0) s_b_wait--;
    axi_bvalid = s_b_pend && (s_b_wait == 0);
    axi_bid = s_b_id; axi_bresp = 2'b00;
    #1;
    if (rset) return;
    if (axi_arvalid && arv_cyc < 0) arv_cyc = cyc;
    if (axi_rvalid && axi_rready) begin
      if (axi_rlast) s_rd_pend = 1'b0; else s_rd_idx++;
    end
    if (axi_arvalid && axi_arready) begin
      ar_log.push_back(int'(axi_arid)); ar_cyc = cyc;
      cap_araddr = axi_araddr; cap_arid = axi_arid; cap_arlen = axi_arlen; cap_arsize = axi_arsize;
      chk("arburst", 32'(axi_arburst), 32'h1);
      s_rd_pend = 1'b1; s_rd_idx = 0; s_rd_len = axi_arlen; s_rd_id = axi_arid;
    end
    for (int c = 0; c < NC; c++) begin
      if (ch_rd_dready[c]) begin
        chk("rdata", ch_rd_data, 32'hD000_0000 | (32'(c) << 16) | 32'(rx_idx[c]));
        rd_cnt[c]++;
        if (ch_rlast[c]) rl_cnt[c]++;
        rx_idx[c]++;
      end
    end
    if (axi_wvalid && axi_wready) begin
      chk("wdata", axi_wdata, 32'hA000_0000 | (32'(s_w_id) << 16) | 32'(s_w_idx));
      chk("wlast", 32'(axi_wlast), 32'(s_w_idx == int'(s_w_len)));
      if (axi_wlast) begin
        s_w_act = 1'b0; s_b_pend = 1'b1; s_b_wait = b_delay; s_b_id = s_w_id;
      end else s_w_idx++;
    end
    if (axi_awvalid && axi_awready) begin
      aw_log.push_back(int'(axi_awid)); aw_cyc = cyc;
      cap_awaddr = axi_awaddr; cap_awid = axi_awid; cap_awlen = axi_awlen;
      s_w_act = 1'b1; s_w_idx = 0; s_w_len = axi_awlen; s_w_id = axi_awid;
    end
    for (int c = 0; c < NC; c++) begin
      if (ch_wr_next[c]) begin
        wn_cnt[c]++;
        if (wc_idx[c] == int'(m_len[c])) wc_act[c] = 1'b0; else wc_idx[c]++;
      end
    end
    if (axi_bvalid && axi_bready) begin s_b_pend = 1'b0; b_cyc = cyc; end
    for (int c = 0; c < NC; c++) begin
      if (ch_wr_finish[c]) fin_cnt[c]++;
      if (ch_valid_clear[c]) begin
        clr_cnt[c]++; m_reqv[c] = 1'b0;
        if (m_we[c]) begin wc_act[c] = 1'b1; wc_idx[c] = 0; end
      end
    end
  endtask

  task automatic run_idle(input string nm, input int maxc);
    int n;
    n = 0;
    do begin step(); n++; end while (!idle() && n < maxc);
    chk(nm, 32'(idle()), 32'h1);
  endtask

  typedef struct {
    int ch; logic we; logic [31:0] addr; logic [7:0] len; int exp_id; int exp_beats;
  } vec_t;
  vec_t tbl [5];

  initial begin
    tbl[0] = '{1, 1'b0, 32'h1FC0_0040, 8'd15, 1, 16};
    tbl[1] = '{0, 1'b1, 32'h8000_0200, 8'd3,  0, 4};
    tbl[2] = '{1, 1'b1, 32'h8000_0300, 8'd0,  1, 1};
    tbl[3] = '{0, 1'b0, 32'h0000_1000, 8'd0,  0, 1};
    tbl[4] = '{0, 1'b0, 32'h0000_1100, 8'd7,  0, 8};

    // reset state
    rset = 1'b1; clear_model(); clear_stats();
    step(); step();
    chk("rst_arvalid", 32'(axi_arvalid), 32'h0);
    chk("rst_awvalid", 32'(axi_awvalid), 32'h0);
    chk("rst_rready", 32'(axi_rready), 32'h0);
    chk("rst_wvalid", 32'(axi_wvalid), 32'h0);
    chk("rst_bready", 32'(axi_bready), 32'h0);
    chk("rst_araddr", axi_araddr, 32'h0);
    chk("rst_vclear", 32'(ch_valid_clear), 32'h0);
    rset = 1'b0;

    // both channels read after reset: ch0 first, then ch1, twice
    for (int r = 0; r < 2; r++) begin
      clear_stats();
      req(0, 1'b0, 32'h0000_2000, 8'd1);
      req(1, 1'b0, 32'h0000_3000, 8'd1);
      run_idle("pair_idle", 100);
      chk("pair_n", 32'(ar_log.size()), 32'd2);
      if (ar_log.size() == 2) begin
        chk("pair_first", 32'(ar_log[0]), 32'd0);
        chk("pair_second", 32'(ar_log[1]), 32'd1);
      end
      chk("pair_beats0", 32'(rd_cnt[0]), 32'd2);
      chk("pair_beats1", 32'(rd_cnt[1]), 32'd2);
    end

    // single-transaction vector table
    for (int v = 0; v < 5; v++) begin
      clear_stats();
      req(tbl[v].ch, tbl[v].we, tbl[v].addr, tbl[v].len);
      run_idle("vec_idle", 200);
      chk("vec_clear", 32'(clr_cnt[tbl[v].ch]), 32'd1);
      if (!tbl[v].we) begin
        chk("vec_araddr", cap_araddr, tbl[v].addr);
        chk("vec_arid", 32'(cap_arid), 32'(tbl[v].exp_id));
        chk("vec_arlen", 32'(cap_arlen), 32'(tbl[v].len));
        chk("vec_arsize", 32'(cap_arsize), 32'd2);
        chk("vec_rbeats", 32'(rd_cnt[tbl[v].ch]), 32'(tbl[v].exp_beats));
        chk("vec_rlast", 32'(rl_cnt[tbl[v].ch]), 32'd1);
      end else begin
        chk("vec_awaddr", cap_awaddr, tbl[v].addr);
        chk("vec_awid", 32'(cap_awid), 32'(tbl[v].exp_id));
        chk("vec_awlen", 32'(cap_awlen), 32'(tbl[v].len));
        chk("vec_wbeats", 32'(wn_cnt[tbl[v].ch]), 32'(tbl[v].exp_beats));
        chk("vec_finish", 32'(fin_cnt[tbl[v].ch]), 32'd1);
      end
    end

    // last read was ch0, so ch1 must win the next contended round
    clear_stats();
    req(0, 1'b0, 32'h0000_2100, 8'd0);
    req(1, 1'b0, 32'h0000_3100, 8'd0);
    run_idle("rr_idle", 100);
    chk("rr_n", 32'(ar_log.size()), 32'd2);
    if (ar_log.size() == 2) begin
      chk("rr_first", 32'(ar_log[0]), 32'd1);
      chk("rr_second", 32'(ar_log[1]), 32'd0);
    end

    // overlapping ch1 write and ch0 read
    clear_stats();
    req(1, 1'b1, 32'h8000_0400, 8'd7);
    req(0, 1'b0, 32'h0000_4000, 8'd7);
    run_idle("ovl_idle", 200);
    chk("ovl_same_cycle", 32'(ar_cyc == aw_cyc && ar_cyc > 0), 32'h1);
    chk("ovl_wnext1", 32'(wn_cnt[1]), 32'd8);
    chk("ovl_rd0", 32'(rd_cnt[0]), 32'd8);
    chk("ovl_finish1", 32'(fin_cnt[1]), 32'd1);
    chk("ovl_clear", 32'(clr_cnt[0] + clr_cnt[1]), 32'd2);

    // toggling rvalid, 3-cycle rready stall, error response
    clear_stats();
    rv_toggle = 1'b1; stall_at = 3; stall_left = 3; rresp_k = 2'b10;
    req(1, 1'b0, 32'h0000_5000, 8'd7);
    run_idle("stall_idle", 200);
    chk("stall_beats", 32'(rd_cnt[1]), 32'd8);
    chk("stall_rlast", 32'(rl_cnt[1]), 32'd1);
    chk("stall_used", 32'(stall_left), 32'd0);
    rv_toggle = 1'b0; stall_at = -1; rresp_k = 2'b00;

    // reset during beat 4 of a read burst
    clear_stats();
    req(0, 1'b0, 32'h0000_6000, 8'd7);
    for (int n = 0; n < 50 && rx_idx[0] < 4; n++) step();
    chk("mid_reached", 32'(rx_idx[0]), 32'd4);
    rset = 1'b1; clear_model();
    step();
    rset = 1'b0;
    chk("mid_arvalid", 32'(axi_arvalid), 32'h0);
    chk("mid_rready", 32'(axi_rready), 32'h0);
    clear_stats();
    req(1, 1'b0, 32'h0000_7000, 8'd3);
    run_idle("mid_idle", 100);
    chk("mid_fresh_id", 32'(cap_arid), 32'd1);
    chk("mid_fresh_beats", 32'(rd_cnt[1]), 32'd4);

    // write in flight then read of the same line
    clear_stats();
    b_delay = 6;
    req(1, 1'b1, 32'h8000_0100, 8'd3);
    for (int n = 0; n < 20 && aw_cyc < 0; n++) step();
    chk("haz_aw_seen", 32'(aw_cyc > 0), 32'h1);
    req(0, 1'b0, 32'h8000_0104, 8'd0);
    run_idle("haz_idle", 200);
`ifdef AXI_RAW_HAZARD_CHK_EN
    chk("haz_ar_after_b", 32'(arv_cyc > b_cyc && b_cyc > 0), 32'h1);
`else
    chk("haz_ar_before_b", 32'(arv_cyc > 0 && arv_cyc < b_cyc), 32'h1);
`endif
    chk("haz_rd_beats", 32'(rd_cnt[0]), 32'd1);
    b_delay = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
